// File: rtl/add_1p_pkg.sv
// Shared definitions for the 15-bit pipelined adder add_1p and its result buffer.
package add_1p_pkg;
  localparam int W           = 15;
  localparam int LAT_DEFAULT = 1;
  typedef logic [W-1:0] sum_t;
endpackage

// File: rtl/add_1p_rbuf_fifo.sv
// First-word-fall-through result FIFO: storage, wrapping pointers and occupancy.
module add_1p_rbuf_fifo
  import add_1p_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     nempty_o,
  output logic [$clog2(DEPTH):0]   occ_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   occ_q, occ_d;
  logic          pop_ok;

  assign nempty_o = (occ_q != '0);
  assign pop_ok   = pop_i & nempty_o;
  assign occ_o    = occ_q;
  assign rdata_o  = nempty_o ? mem[rd_q] : '0;

  always_comb begin
    wr_d  = push_i ? wr_q + AW'(1) : wr_q;
    rd_d  = pop_ok ? rd_q + AW'(1) : rd_q;
    occ_d = occ_q;
    case ({push_i, pop_ok})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // Storage is deliberately not reset; empty reads are masked to zero above.
  always_ff @(posedge clk) begin
    if (push_i) mem[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/add_1p_rbuf.sv
// Result-capture stage behind add_1p: valid pipe, credit-gated issue, FWFT output.
// Optional ADD_1P_RBUF_CNT_EN adds a 16-bit wrapping pop counter on result_count.
module add_1p_rbuf
  import add_1p_pkg::*;
#(
  parameter int LAT   = LAT_DEFAULT,
  parameter int DEPTH = 4,
  parameter int W     = add_1p_pkg::W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           sum,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef ADD_1P_RBUF_CNT_EN
  ,
  output logic [15:0]            result_count
`endif
);
  logic [LAT-1:0] vpipe_q, vpipe_d;
  logic [7:0]     inflight;
  logic           issue, pop;

  assign issue = in_valid & in_ready;
  assign pop   = out_valid & out_ready;

  // Credit counts only registered state, so in_ready has no path from in_valid/out_ready.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + 8'(vpipe_q[i]);
  end
  assign in_ready = (8'(occupancy) + inflight) < 8'(DEPTH);

  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = issue;
    for (int i = 1; i < LAT; i++) vpipe_d[i] = vpipe_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vpipe_q <= '0;
    else       vpipe_q <= vpipe_d;
  end

  add_1p_rbuf_fifo #(.DEPTH(DEPTH), .DW(W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_i   (vpipe_q[LAT-1]),
    .wdata_i  (sum),
    .pop_i    (out_ready),
    .rdata_o  (out_data),
    .nempty_o (out_valid),
    .occ_o    (occupancy)
  );

`ifdef ADD_1P_RBUF_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 16'd1;
  end
  assign result_count = cnt_q;
`else
  logic unused_pop;
  assign unused_pop = pop;
`endif
endmodule

// File: tb/tb_add_1p_rbuf.sv
// Directed bench for add_1p_rbuf (LAT=1, DEPTH=4) with a registered add_1p model and result scoreboard.
module tb_add_1p_rbuf;
  import add_1p_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  sum_t        x = '0, y = '0, sum, out_data;
  logic [2:0]  occupancy;
`ifdef ADD_1P_RBUF_CNT_EN
  logic [15:0] result_count;
`endif

  int   checks = 0, errors = 0, nis = 0, npop = 0, base;
  sum_t q[$];

  always #5 clk = ~clk;

  // add_1p model: one-cycle registered 15-bit adder, wraps modulo 2^15
  always_ff @(posedge clk) sum <= x + y;

  add_1p_rbuf #(.LAT(1), .DEPTH(4), .W(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef ADD_1P_RBUF_CNT_EN
    ,
    .result_count (result_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe handshakes mid-cycle, then advance past the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (!reset) begin
      if (in_valid && in_ready) begin
        q.push_back(sum_t'(x + y));
        nis++;
      end
      if (out_valid && out_ready) begin
        npop++;
        checks++;
        assert (q.size() > 0) else begin
          errors++;
          $error("FAIL spurious_out observed=%0h expected=none", out_data);
        end
        if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input sum_t a, input sum_t b);
    x = a; y = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_occ",       32'(occupancy), 32'd0);
    reset = 1'b0;

    // 1: single op, first cycle after release
    issue(15'd10, 15'd0);
    chk("t1_valid_early", 32'(out_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_occ1",  32'(occupancy), 32'd1);
    chk("t1_data",  32'(out_data),  32'd10);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t1_occ0",  32'(occupancy), 32'd0);

    // 2: back-to-back with out_ready high
    out_ready = 1'b1;
    base = npop;
    issue(15'h07D2, 15'h07D2);
    in_valid = 1'b1; x = 15'h07FF; y = 15'h07FF; tick();
    x = 15'h04AA; y = 15'h0057; tick();
    in_valid = 1'b0; tick();
    chk("t2_pops_by_4", 32'(npop - base), 32'd2);
    tick();
    chk("t2_pops_by_5", 32'(npop - base), 32'd3);
    chk("t2_drained", 32'(q.size()), 32'd0);

    // 3: wrap-around passes through
    out_ready = 1'b0;
    issue(15'h7FFF, 15'h0000);
    issue(15'h7FFF, 15'h0001);
    tick();
    chk("t3_head", 32'(out_data), 32'h7FFF);
    out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
    chk("t3_drained", 32'(q.size()), 32'd0);

    // 4: backpressure credit limit
    base = nis;
    in_valid = 1'b1; x = 15'd100; y = 15'd1;
    for (int i = 0; i < 7; i++) begin
      tick();
      x = x + 15'd1;
    end
    in_valid = 1'b0;
    chk("t4_issues",   32'(nis - base), 32'd4);
    chk("t4_in_ready", 32'(in_ready),   32'd0);
    chk("t4_occ_full", 32'(occupancy),  32'd4);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t4_ready_back", 32'(in_ready),  32'd1);
    chk("t4_occ3",       32'(occupancy), 32'd3);
    out_ready = 1'b1; tick(); tick(); tick(); out_ready = 1'b0;
    chk("t4_occ0", 32'(occupancy), 32'd0);

    // 5: simultaneous push and pop at occupancy 2
    issue(15'd1, 15'd2);
    issue(15'd3, 15'd4);
    issue(15'd5, 15'd6);
    chk("t5_occ2_pre", 32'(occupancy), 32'd2);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t5_occ2_post", 32'(occupancy), 32'd2);
    chk("t5_head",      32'(out_data),  32'(q[0]));
    out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
    chk("t5_drained", 32'(q.size()), 32'd0);

`ifdef ADD_1P_RBUF_CNT_EN
    chk("cnt_before_rst", 32'(result_count), 32'(npop));
`endif

    // 6: reset drops an in-flight result
    issue(15'd77, 15'd1);
    reset = 1'b1;
    q.delete();
    tick();
    reset = 1'b0;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_occ",       32'(occupancy), 32'd0);
    chk("t6_in_ready",  32'(in_ready),  32'd1);
`ifdef ADD_1P_RBUF_CNT_EN
    chk("t6_count", 32'(result_count), 32'd0);
`endif
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t6_no_late_out", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
